// File: rtl/display_pkg.sv
// Shared display-bus types: digit geometry, segment code table, capture FSM states.
package display_pkg;

    localparam int unsigned DIGITS   = 8;
    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned VAL_W    = DIGITS * NIBBLE_W;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned HEX_CNT  = 16;

    // Active-low segment pattern, bit order {g,f,e,d,c,b,a}
    typedef logic [6:0] seg7_t;

    // One observation of the display bus (digit select + segment lines incl. dp)
    typedef struct packed {
        logic [DIGITS-1:0] sel;
        logic [7:0]        seg;
    } disp_pair_t;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } cap_state_t;

    // Hex digit -> active-low segment pattern; the decoder inverts this table
    localparam seg7_t SEG7_TABLE [HEX_CNT] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // True when exactly one active-low select line is asserted
    function automatic logic sel_legal(input logic [DIGITS-1:0] sel);
        logic [DIGITS-1:0] act;
        act = ~sel;
        return (act != '0) && ((act & (act - DIGITS'(1))) == '0);
    endfunction

    // Index of the asserted (low) select line; only meaningful for a legal select
    function automatic logic [IDX_W-1:0] sel_to_idx(input logic [DIGITS-1:0] sel);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!sel[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7tohex.sv
// Combinational seven-segment to hex decoder; inverse of the display encoder.
module seg7tohex
    import display_pkg::*;
(
    input  seg7_t                seg,
    output logic [NIBBLE_W-1:0]  nibble_c,
    output logic                 valid_c
);

    // Table search; patterns outside the table report invalid with nibble 0
    always_comb begin
        nibble_c = '0;
        valid_c  = 1'b0;
        for (int i = 0; i < HEX_CNT; i++) begin
            if (seg == SEG7_TABLE[i]) begin
                nibble_c = NIBBLE_W'(i);
                valid_c  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display8digit_capture.sv
// Display bus monitor: captures settled digits and reassembles the 32-bit frame.
module display8digit_capture
    import display_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned SYNC_STAGES   = 2
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        segments,
    input  logic [DIGITS-1:0] digitselect,
    output logic [VAL_W-1:0]  val,
    output logic              val_valid,
    output logic              frame_err,
    output logic [DIGITS-1:0] digit_mask
);

    localparam int unsigned CNT_W = 8;

    logic [DIGITS-1:0] sel_sync [SYNC_STAGES];
    logic [7:0]        seg_sync [SYNC_STAGES];
    logic [DIGITS-1:0] sel_s;
    logic [7:0]        seg_s;

    disp_pair_t        cur_c;
    disp_pair_t        ref_q, ref_d;
    cap_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              legal_c;
    logic              capture_c;

    logic [NIBBLE_W-1:0] dec_nibble_c;
    logic                dec_valid_c;
    logic [IDX_W-1:0]    idx_c;

    logic [VAL_W-1:0]  shadow_q;
    logic [DIGITS-1:0] mask_q;
    logic              err_r;

    // Input synchronisers; idle bus (all high) after reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sel_sync[i] <= '1;
                seg_sync[i] <= '1;
            end
        end else begin
            sel_sync[0] <= digitselect;
            seg_sync[0] <= segments;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sel_sync[i] <= sel_sync[i-1];
                seg_sync[i] <= seg_sync[i-1];
            end
        end
    end

    assign sel_s     = sel_sync[SYNC_STAGES-1];
    assign seg_s     = seg_sync[SYNC_STAGES-1];
    assign cur_c.sel = sel_s;
    assign cur_c.seg = seg_s;
    assign legal_c   = sel_legal(sel_s);

    // Capture FSM state, settle counter and reference pair
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT;
            cnt_q   <= '0;
            ref_q   <= '{sel: '1, seg: '1};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
        end
    end

    // Next-state: wait for a legal select, require a stable dwell, capture once per dwell
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ref_d     = ref_q;
        capture_c = 1'b0;
        if (!legal_c) begin
            state_d = WAIT;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                WAIT: begin
                    state_d = SETTLE;
                    cnt_d   = CNT_W'(1);
                    ref_d   = cur_c;
                end
                SETTLE: begin
                    if (cur_c != ref_q) begin
                        ref_d = cur_c;
                        cnt_d = CNT_W'(1);
                    end else if (cnt_q == CNT_W'(SETTLE_CYCLES)) begin
                        capture_c = 1'b1;
                        state_d   = HELD;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (cur_c != ref_q) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    seg7tohex u_dec (
        .seg      (ref_q.seg[6:0]),
        .nibble_c (dec_nibble_c),
        .valid_c  (dec_valid_c)
    );

    assign idx_c = sel_to_idx(ref_q.sel);

    // Shadow frame assembly, frame completion and output pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q  <= '0;
            mask_q    <= '0;
            err_r     <= 1'b0;
            val       <= '0;
            val_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            val_valid <= 1'b0;
            frame_err <= 1'b0;
            if (mask_q == '1) begin
                if (!err_r) begin
                    val       <= shadow_q;
                    val_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
                mask_q <= '0;
                err_r  <= 1'b0;
            end else if (capture_c) begin
                for (int d = 0; d < DIGITS; d++) begin
                    if (idx_c == IDX_W'(d)) begin
                        shadow_q[d*NIBBLE_W +: NIBBLE_W] <= dec_valid_c ? dec_nibble_c : '0;
                        mask_q[d]                        <= 1'b1;
                    end
                end
                if (!dec_valid_c) begin
                    err_r <= 1'b1;
                end
            end
        end
    end

    assign digit_mask = mask_q;

endmodule

// File: tb/tb_display8digit_capture.sv
// Directed bench for display8digit_capture with a frame scoreboard.
module tb_display8digit_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  segments;
    logic [7:0]  digitselect;
    logic [31:0] val;
    logic        val_valid;
    logic        frame_err;
    logic [7:0]  digit_mask;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        bit          is_err;
        logic [31:0] v;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] good_val = 32'h0;

    display8digit_capture #(
        .SETTLE_CYCLES (16),
        .SYNC_STAGES   (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .segments    (segments),
        .digitselect (digitselect),
        .val         (val),
        .val_valid   (val_valid),
        .frame_err   (frame_err),
        .digit_mask  (digit_mask)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic drive(input logic [7:0] sel, input logic [7:0] seg, input int cycles);
        @(posedge clk);
        #1;
        digitselect = sel;
        segments    = seg;
        repeat (cycles) @(posedge clk);
    endtask

    task automatic show(input int idx, input logic [3:0] nib, input int cycles);
        drive(~(8'd1 << idx), {1'b1, enc(nib)}, cycles);
    endtask

    task automatic idle(input int cycles);
        drive(8'hFF, 8'hFF, cycles);
    endtask

    task automatic show_digits(input logic [31:0] v, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            show(k, v[k*4 +: 4], 100);
        end
    endtask

    task automatic push(input bit is_err, input logic [31:0] v);
        exp_t e;
        e.is_err = is_err;
        e.v      = v;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: every output pulse must match the next expected frame
    always @(negedge clk) begin
        if (reset_n === 1'b1 && (val_valid || frame_err)) begin
            check("pulse_exclusive", {31'b0, val_valid & frame_err}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", {30'b0, val_valid, frame_err}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check(mon_e.is_err ? "frame_err_pulse" : "val_valid_pulse",
                      {30'b0, val_valid, frame_err},
                      mon_e.is_err ? 32'd1 : 32'd2);
                check("val_at_pulse", val, mon_e.v);
            end
        end
    end

    initial begin
        int          order[8];
        logic [31:0] v;

        reset_n     = 1'b0;
        segments    = 8'hFF;
        digitselect = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_val", val, 32'h0);
        check("reset_val_valid", {31'b0, val_valid}, 32'd0);
        check("reset_frame_err", {31'b0, frame_err}, 32'd0);
        check("reset_digit_mask", {24'b0, digit_mask}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(5);

        // Frame 1: digits in order
        v = 32'h12345678;
        push(1'b0, v);
        show_digits(v, 0, 3);
        @(negedge clk);
        check("f1_partial_mask", {24'b0, digit_mask}, 32'h0F);
        show_digits(v, 4, 7);
        idle(20);
        good_val = v;
        @(negedge clk);
        check("f1_val", val, good_val);
        check("f1_mask_cleared", {24'b0, digit_mask}, 32'd0);

        // Frame 2: scrambled digit order
        v = 32'hDEADBEEF;
        order = '{7, 3, 0, 5, 1, 6, 2, 4};
        push(1'b0, v);
        for (int k = 0; k < 7; k++) begin
            show(order[k], v[order[k]*4 +: 4], 100);
        end
        @(negedge clk);
        check("f2_mask_seven", {24'b0, digit_mask}, 32'hEF);
        check("f2_val_held", val, good_val);
        show(order[7], v[order[7]*4 +: 4], 100);
        idle(20);
        good_val = v;
        @(negedge clk);
        check("f2_val", val, good_val);

        // Frame 3: short segment glitch during digit 2 dwell
        v = 32'h89ABCDEF;
        push(1'b0, v);
        show_digits(v, 0, 1);
        show(2, v[11:8], 40);
        drive(~8'h04, {1'b1, 7'h79}, 5);
        show(2, v[11:8], 60);
        show_digits(v, 3, 7);
        idle(20);
        good_val = v;
        @(negedge clk);
        check("f3_glitch_val", val, good_val);

        // Frame 4: undecodable digit 4
        v = 32'h55555555;
        push(1'b1, good_val);
        show_digits(v, 0, 3);
        drive(~8'h10, 8'hFF, 100);
        show_digits(v, 5, 7);
        idle(20);
        @(negedge clk);
        check("f4_val_kept", val, good_val);
        check("f4_mask_cleared", {24'b0, digit_mask}, 32'd0);

        // Frame 5: clean frame after the error
        v = 32'h00000001;
        push(1'b0, v);
        show_digits(v, 0, 7);
        idle(20);
        good_val = v;
        @(negedge clk);
        check("f5_val", val, good_val);

        // Illegal two-hot select produces no capture
        v = 32'hA5A55A5A;
        show_digits(v, 0, 1);
        drive(8'hFC, {1'b1, enc(4'h3)}, 200);
        @(negedge clk);
        check("twohot_mask", {24'b0, digit_mask}, 32'h03);
        show_digits(v, 2, 4);
        @(negedge clk);
        check("five_digit_mask", {24'b0, digit_mask}, 32'h1F);

        // Async reset mid-frame
        @(posedge clk);
        #1;
        reset_n     = 1'b0;
        digitselect = 8'hFF;
        segments    = 8'hFF;
        #1;
        check("midreset_mask", {24'b0, digit_mask}, 32'd0);
        check("midreset_val", val, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset_n  = 1'b1;
        good_val = 32'h0;
        show_digits(v, 5, 7);
        idle(20);
        @(negedge clk);
        check("postreset_partial_mask", {24'b0, digit_mask}, 32'hE0);
        check("postreset_val", val, good_val);
        push(1'b0, v);
        show_digits(v, 0, 4);
        idle(20);
        good_val = v;
        @(negedge clk);
        check("postreset_frame_val", val, good_val);
        check("postreset_mask_cleared", {24'b0, digit_mask}, 32'd0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
